// File: rtl/inst_fetch_if.sv
// inst_fetch_if
// Delivery bus between the fetch stage and the register-file/ALU stage.
// The producer presents one instruction word, its decoded fields and its
// byte address under a valid/ready handshake; the consumer may stall it.
//
// Signals:
//   out_valid  producer -> consumer  instruction and fields are valid
//   out_ready  consumer -> producer  consumer accepts the presented instruction
//   instr      producer -> consumer  full 32-bit instruction word
//   op/rs/rt/rd/shamt/func/imm16     decoded slices of instr
//   pc_out     producer -> consumer  byte address of the presented instruction
interface inst_fetch_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [31:0] pc_out;

    modport master (
        output out_valid, instr, op, rs, rt, rd, shamt, func, imm16, pc_out,
        input  out_ready
    );

    modport slave (
        input  out_valid, instr, op, rs, rt, rd, shamt, func, imm16, pc_out,
        output out_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch
// Instruction fetch stage: holds the PC and a loadable instruction memory and
// presents one MIPS-format instruction per cycle downstream. Supports consumer
// stalls, PC redirect (branches/jumps) and a halt opcode that stops fetching.
//
// Parameters:
//   MEM_AW   instruction memory address width in words (depth 2^MEM_AW)
//   HALT_OP  opcode that stops fetching once accepted
// Ports:
//   Clk             rising-edge clock
//   Rst             asynchronous active-low reset
//   prog_we         program-load write enable
//   prog_addr       word address for program load
//   prog_wdata      instruction word to write
//   redirect_valid  load a new PC this cycle
//   redirect_pc     target byte address (bits [1:0] treated as 0)
//   fetch           delivery bus (master side)
//   halted          halt opcode accepted; fetching stopped
//   inst_count      number of accepted instructions (wraps)
module inst_fetch #(
    parameter int          MEM_AW  = 6,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              prog_we,
    input  logic [MEM_AW-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    inst_fetch_if.master      fetch,
    output logic              halted,
    output logic [31:0]       inst_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] nfa;
    logic [31:0] redirect_target;
    logic        load;
    logic        fire;

    logic [31:0] mem [2**MEM_AW];

    // Word-align the redirect target by masking rather than slicing so every
    // bit of the input is consumed.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Program-load port. The memory is not touched by reset, and writes are
    // accepted in every state. A same-cycle read of the written word sees the
    // old contents because both sides update on the same edge.
    always_ff @(posedge Clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Next-state and next-fetch-address logic. 'load' means the register
    // stage captures mem[nfa] this edge; it is withheld on the edge that
    // accepts a halt so the halt word and its PC stay presented.
    always_comb begin
        next_state = state;
        nfa        = pc;
        load       = 1'b0;
        fire       = 1'b0;
        case (state)
            BOOT: begin
                nfa        = redirect_valid ? redirect_target : pc;
                load       = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                fire = fetch.out_ready & ~redirect_valid;
                if (redirect_valid) begin
                    nfa = redirect_target;
                end else if (fire) begin
                    nfa = pc + 32'd4;
                end
                if (fire && (instr_q[31:26] == HALT_OP)) begin
                    next_state = HALT;
                end else begin
                    load = 1'b1;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // State, PC, presented instruction and accepted-instruction counter.
    // The memory is indexed by the word bits of nfa, so higher PC bits alias.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= BOOT;
            pc         <= 32'd0;
            instr_q    <= 32'd0;
            inst_count <= 32'd0;
        end else begin
            state <= next_state;
            if (load) begin
                pc      <= nfa;
                instr_q <= mem[nfa[MEM_AW+1:2]];
            end
            if (fire) begin
                inst_count <= inst_count + 32'd1;
            end
        end
    end

    assign fetch.out_valid = (state == RUN);
    assign halted          = (state == HALT);
    assign fetch.instr     = instr_q;
    assign fetch.pc_out    = pc;
    assign fetch.op        = instr_q[31:26];
    assign fetch.rs        = instr_q[25:21];
    assign fetch.rt        = instr_q[20:16];
    assign fetch.rd        = instr_q[15:11];
    assign fetch.shamt     = instr_q[10:6];
    assign fetch.func      = instr_q[5:0];
    assign fetch.imm16     = instr_q[15:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
// Self-checking bench for inst_fetch. A behavioural model tracks memory
// contents, the presented PC/instruction, the accepted count and whether the
// stage is booting, running or halted; every cycle all outputs are compared
// against it. Directed steps cover the load/run, stall, redirect, wrap, halt
// and async-reset scenarios, followed by a randomized phase.
module tb_inst_fetch;
    localparam int MEM_AW = 6;
    localparam int DEPTH  = 64;

    logic              Clk;
    logic              Rst;
    logic              prog_we;
    logic [MEM_AW-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halted;
    logic [31:0]       inst_count;

    inst_fetch_if bus ();

    inst_fetch #(
        .MEM_AW (MEM_AW),
        .HALT_OP(6'b111111)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch         (bus),
        .halted        (halted),
        .inst_count    (inst_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    bit          m_valid;
    bit          m_halted;

    int tests_run;
    int tests_failed;

    logic [31:0] a_words [4];
    logic [31:0] tmp_word;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b111111) w[31] = 1'b0;
        return w;
    endfunction

    function automatic int word_index(input logic [31:0] byte_addr);
        return int'(byte_addr / 4) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid",  {31'd0, bus.out_valid}, {31'd0, m_valid});
        check("halted",     {31'd0, halted},        {31'd0, m_halted});
        check("instr",      bus.instr,              m_instr);
        check("pc_out",     bus.pc_out,             m_pc);
        check("inst_count", inst_count,             m_count);
        check("op",    {26'd0, bus.op},    {26'd0, m_instr[31:26]});
        check("rs",    {27'd0, bus.rs},    {27'd0, m_instr[25:21]});
        check("rt",    {27'd0, bus.rt},    {27'd0, m_instr[20:16]});
        check("rd",    {27'd0, bus.rd},    {27'd0, m_instr[15:11]});
        check("shamt", {27'd0, bus.shamt}, {27'd0, m_instr[10:6]});
        check("func",  {26'd0, bus.func},  {26'd0, m_instr[5:0]});
        check("imm16", {16'd0, bus.imm16}, {16'd0, m_instr[15:0]});
    endtask

    task automatic model_reset();
        m_pc     = 32'd0;
        m_instr  = 32'd0;
        m_count  = 32'd0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    // Effect of one rising edge on the model, from the rules of the stage:
    // booting presents the target (or current) address; running either
    // follows a redirect, advances on an accepted instruction, or holds.
    task automatic model_edge(input logic we, input logic [MEM_AW-1:0] addr,
                              input logic [31:0] wdata, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
        logic [31:0] target;
        target = (rpc / 4) * 4;
        if (Rst == 1'b0) begin
            model_reset();
        end else if (!m_halted) begin
            if (!m_valid) begin
                if (rv) m_pc = target;
                m_valid = 1'b1;
                m_instr = m_mem[word_index(m_pc)];
            end else if (rv) begin
                m_pc    = target;
                m_instr = m_mem[word_index(m_pc)];
            end else if (rdy) begin
                m_count = m_count + 1;
                if (m_instr[31:26] == 6'b111111) begin
                    m_halted = 1'b1;
                    m_valid  = 1'b0;
                end else begin
                    m_pc    = m_pc + 4;
                    m_instr = m_mem[word_index(m_pc)];
                end
            end else begin
                m_instr = m_mem[word_index(m_pc)];
            end
        end
        if (we) m_mem[addr] = wdata;
    endtask

    task automatic apply_stimulus(input logic we, input logic [MEM_AW-1:0] addr,
                                  input logic [31:0] wdata, input logic rv,
                                  input logic [31:0] rpc, input logic rdy);
        prog_we        = we;
        prog_addr      = addr;
        prog_wdata     = wdata;
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.out_ready  = rdy;
        model_edge(we, addr, wdata, rv, rpc, rdy);
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    task automatic run_cycle(input logic rdy);
        apply_stimulus(1'b0, '0, 32'd0, 1'b0, 32'd0, rdy);
    endtask

    task automatic redirect_to(input logic [31:0] target, input logic rdy);
        apply_stimulus(1'b0, '0, 32'd0, 1'b1, target, rdy);
    endtask

    // Asserts reset between clock edges, checks the immediate effect, holds
    // it across one edge, then releases just after that edge.
    task automatic async_reset_pulse();
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        run_cycle(1'b0);
        Rst = 1'b1;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        Rst            = 1'b1;
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_wdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        bus.out_ready  = 1'b0;
        model_reset();

        // Reset state
        #1;
        Rst = 1'b0;
        #1;
        check_outputs();

        // Program load while held in reset
        for (int i = 0; i < DEPTH; i++) begin
            tmp_word = rand_word();
            if (i < 4) a_words[i] = tmp_word;
            apply_stimulus(1'b1, MEM_AW'(i), tmp_word, 1'b0, 32'd0, 1'b0);
        end

        // Release: first edge presents mem[0]
        Rst = 1'b1;
        run_cycle(1'b1);
        check("first_instr", bus.instr, a_words[0]);
        check("first_pc", bus.pc_out, 32'd0);
        run_cycle(1'b1);
        check("a1_instr", bus.instr, a_words[1]);

        // Stall on A1 for three cycles
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0);
            check("stall_pc", bus.pc_out, 32'd4);
            check("stall_instr", bus.instr, a_words[1]);
        end
        run_cycle(1'b1);
        check("after_stall", bus.instr, a_words[2]);
        run_cycle(1'b1);
        run_cycle(1'b1);
        check("count_after_four", inst_count, 32'd4);

        // Redirect with ready high: presented word discarded, not counted
        redirect_to(32'h0000_0011, 1'b1);
        check("redirect_pc", bus.pc_out, 32'h0000_0010);
        check("redirect_count", inst_count, 32'd4);

        // Write the presented word during a stall: old data first, new next
        tmp_word = rand_word();
        apply_stimulus(1'b1, MEM_AW'(4), tmp_word, 1'b0, 32'd0, 1'b0);
        run_cycle(1'b0);
        check("stall_write", bus.instr, tmp_word);

        // Address aliasing and 32-bit PC wrap
        redirect_to(32'h0000_00FC, 1'b0);
        run_cycle(1'b1);
        check("alias_pc", bus.pc_out, 32'h0000_0100);
        redirect_to(32'hFFFF_FFFC, 1'b0);
        run_cycle(1'b1);
        check("wrap_pc", bus.pc_out, 32'd0);

        // Async reset mid-run, then memory still intact
        async_reset_pulse();
        run_cycle(1'b1);
        check("reset_reload", bus.instr, m_mem[0]);

        // Halt at word 2: three accepted instructions, then stopped
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        apply_stimulus(1'b1, MEM_AW'(2), 32'hFC00_0000, 1'b0, 32'd0, 1'b0);
        Rst = 1'b1;
        run_cycle(1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_count", inst_count, 32'd3);
        redirect_to(32'h0000_0040, 1'b1);
        check("halt_ignores_redirect", bus.pc_out, 32'd8);
        tmp_word = rand_word();
        apply_stimulus(1'b1, MEM_AW'(2), tmp_word, 1'b0, 32'd0, 1'b1);

        // Randomized phase
        async_reset_pulse();
        for (int n = 0; n < 400; n++) begin
            logic              we;
            logic [MEM_AW-1:0] addr;
            logic [31:0]       wdata;
            logic              rv;
            logic [31:0]       rpc;
            logic              rdy;
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                async_reset_pulse();
            end
            we    = ($urandom_range(0, 4) == 0);
            addr  = MEM_AW'($urandom);
            wdata = ($urandom_range(0, 9) == 0) ? (32'hFC00_0000 | ($urandom & 32'h03FF_FFFF))
                                                : rand_word();
            rv    = ($urandom_range(0, 5) == 0);
            rpc   = $urandom;
            rdy   = ($urandom_range(0, 3) != 0);
            apply_stimulus(we, addr, wdata, rv, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the single-cycle R-type datapath: holds the PC and a loadable instruction memory, and presents one decoded 32-bit MIPS-format instruction per cycle to the register-file/ALU stage. Delivery uses a valid/ready handshake, so the consumer can stall. Also supports PC redirect for branches/jumps and a halt opcode. Sits directly upstream of the register file and the func-to-alu_op decode.

## Interface
- MEM_AW, 6, instruction memory address width in words (depth 2^MEM_AW)
- HALT_OP, 6'b111111, opcode that stops fetching once accepted
- Clk  input  1  clock, rising-edge
- Rst  input  1  reset, asynchronous, active-low
- prog_we  input  1  program-load write enable
- prog_addr  input  MEM_AW  word address for program load
- prog_wdata  input  32  instruction word to write
- redirect_valid  input  1  load new PC this cycle
- redirect_pc  input  32  target byte address; bits [1:0] ignored (treated as 0)
- out_ready  input  1  consumer accepts the current instruction
- out_valid  output  1  instr and fields are valid
- instr  output  32  full instruction word
- op, rs, rt, rd, func  output  6/5/5/5/6  instr[31:26], [25:21], [20:16], [15:11], [5:0]
- shamt  output  5  instr[10:6]
- imm16  output  16  instr[15:0]
- pc_out  output  32  byte address of the presented instruction
- halted  output  1  halt opcode accepted; fetching stopped
- inst_count  output  32  number of accepted instructions

## Operation
- Memory: 2^MEM_AW x 32, synchronous read, synchronous write. Indexed by address[MEM_AW+1:2]; higher PC bits alias (wrap). Not cleared by reset. Writes are allowed in any state. A write and a read to the same word in one cycle return the old data.
- fire = out_valid & out_ready & ~redirect_valid.
- Next fetch address (nfa), in priority order:
  - {redirect_pc[31:2],2'b00} if redirect_valid;
  - else pc+4 if fire (32-bit wrap: 32'hFFFF_FFFC -> 0);
  - else pc.
- States:
  - BOOT: entered on reset; out_valid=0. The read of nfa is issued. The next edge moves to RUN.
  - RUN: out_valid=1. Each edge: instr <= mem[nfa], pc <= nfa, pc_out <= nfa.
    - If fire and the presented op == HALT_OP: go to HALT. instr and pc are not updated that edge.
    - Redirect in RUN discards the presented instruction. It is not counted and does not trigger halt, even if out_ready=1. The target instruction is valid the next cycle (no bubble).
  - HALT: out_valid=0, halted=1. redirect_valid and out_ready are ignored; only Rst exits. Program-load writes still work.
- Redirect in BOOT: pc <= target, and the next state is RUN with mem[target].
- inst_count increments by 1 on each fire (a halt instruction is counted) and wraps at 2^32.
- Field outputs are pure slices of instr.

## Timing
- Reset (async assert, Rst=0): state=BOOT, pc=0, pc_out=0, instr=0 (all fields 0), out_valid=0, halted=0, inst_count=0.
- Release: the first rising edge with Rst=1 latches mem[0]; out_valid=1 and pc_out=0 from then on.
- Latency: redirect or fire at edge t yields the new instruction visible after edge t. Throughput is 1 instruction/cycle with out_ready held high.
- Stall (out_valid=1, out_ready=0, no redirect): instr, pc_out and fields hold stable, and the same address is re-read every cycle. A prog write to that address during a stall updates instr on the following edge.
- Reset mid-operation: immediate return to reset values. Memory contents are retained.

## Test plan
- Load words A0..A3 at 0..3, release reset, out_ready=1 -> out_valid rises one edge after release. pc_out sequence 0,4,8,12 with instr A0..A3 on consecutive cycles. inst_count=4 after four cycles.
- Stall: out_ready=0 for 3 cycles while instr=A1 -> instr=A1 and pc_out=4 stable all 3 cycles, inst_count unchanged. Raise out_ready -> A2 on the next cycle.
- Redirect: redirect_valid=1, redirect_pc=32'h0000_0011 while A1 is presented with out_ready=1 -> next cycle pc_out=0x10, instr=mem[4]. inst_count not incremented for A1.
- Wrap: MEM_AW=6, start at pc 0xFC -> next pc 0x100 presents mem[0]. Redirect to 32'hFFFF_FFFC, then fire -> pc_out=0.
- Halt: mem[2]=32'hFC00_0000, run from 0 -> after accepting it, out_valid=0, halted=1, inst_count=3. A later redirect is ignored.
- Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately. After release, mem[0] is presented again with contents intact.
